// File: rtl/rr_decode_arbiter_pkg.sv
// Shared types and constants for the round-robin decode arbiter.
package rr_decode_arbiter_pkg;

    localparam int NUM_REQ      = 8;
    localparam int IDX_W        = 3;
    localparam int DEF_MAX_HOLD = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // First set request bit scanning ptr, ptr+1, ... with modulo wrap.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req_vec,
                                                 input logic [IDX_W-1:0]   ptr);
        logic [IDX_W-1:0] cand;
        rr_pick = ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = ptr + IDX_W'(k);
            if (req_vec[cand]) rr_pick = cand;
        end
    endfunction

endpackage

// File: rtl/rr_decode_arbiter_if.sv
// Requester/resource-side bundle of the arbiter; rel is the owner's release strobe.
interface rr_decode_arbiter_if;
    import rr_decode_arbiter_pkg::*;

    logic [NUM_REQ-1:0] req;
    logic               rel;
    logic [IDX_W-1:0]   gnt_idx;
    logic               gnt_en;
    logic [NUM_REQ-1:0] gnt;
    logic               busy;
    logic               timeout;

    modport master (output req, rel,
                    input  gnt_idx, gnt_en, gnt, busy, timeout);
    modport slave  (input  req, rel,
                    output gnt_idx, gnt_en, gnt, busy, timeout);

endinterface

// File: rtl/rr_grant_decoder.sv
// Combinational 3-to-8 decoder with enable; all-zero output when disabled.
module rr_grant_decoder (
    input  logic [2:0] in,
    input  logic       en,
    output logic [7:0] out
);

    always_comb begin
        out = 8'd0;
        if (en) out[in] = 1'b1;
    end

endmodule

// File: rtl/rr_decode_arbiter.sv
// Round-robin arbiter over 8 requesters with break-before-make hand-over
// and a bounded hold time that forces a revoke.
//
// state | meaning
// IDLE  | no owner; arbitrate among req starting at ptr
// GRANT | gnt_idx owns the resource; hold counter running
module rr_decode_arbiter
    import rr_decode_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = DEF_MAX_HOLD,
    parameter int CNT_W    = 8
) (
    input  logic                clk,
    input  logic                rst,
    rr_decode_arbiter_if.slave  bus
);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic             timeout_q, timeout_d;
    logic             any_req;
    logic             end_norm;
    logic             end_force;
    logic             gnt_en_w;

    assign any_req   = |bus.req;
    // A normal release always beats the hold limit on the same edge.
    assign end_norm  = bus.rel || !bus.req[idx_q];
    assign end_force = !end_norm && (hold_q == CNT_W'(MAX_HOLD - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            idx_q     <= '0;
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            idx_q     <= idx_d;
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (any_req) state_d = GRANT;
            GRANT: if (end_norm || end_force) state_d = IDLE;
        endcase
    end

    always_comb begin
        ptr_d     = ptr_q;
        idx_d     = idx_q;
        hold_d    = hold_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    idx_d  = rr_pick(bus.req, ptr_q);
                    hold_d = '0;
                end
            end
            GRANT: begin
                if (end_norm || end_force) begin
                    ptr_d     = idx_q + IDX_W'(1);
                    timeout_d = end_force;
                end else begin
                    hold_d = hold_q + CNT_W'(1);
                end
            end
        endcase
    end

    assign gnt_en_w    = (state_q == GRANT);
    assign bus.gnt_en  = gnt_en_w;
    assign bus.busy    = gnt_en_w;
    assign bus.gnt_idx = idx_q;
    assign bus.timeout = timeout_q;

    rr_grant_decoder u_dec (
        .in  (idx_q),
        .en  (gnt_en_w),
        .out (bus.gnt)
    );

endmodule

// File: doc/rr_decode_arbiter.md
Name: rr_decode_arbiter

Overview:
- Round-robin arbiter that shares one 8-way resource among 8 requesters.
- Selects a winner, drives a 3-bit grant index plus enable, and produces the one-hot grant vector through a 3-to-8 enable-gated decoder.
- Enforces break-before-make ownership changes and a bounded hold time with forced revoke.
- Sits between requesting agents and the shared resource select lines.

Parameters:
- MAX_HOLD, 16, max cycles one owner may hold the grant; legal range 1..255.
- CNT_W, 8, width of the hold counter; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk      input   1  rising-edge clock.
- rst      input   1  synchronous reset, active-high.
- req      input   8  request per agent; bit i = agent i.
- release  input   1  current owner relinquishes the grant; ignored when no grant is active.
- gnt_idx  output  3  index of the current owner; holds its last value when gnt_en=0.
- gnt_en   output  1  grant active.
- gnt      output  8  one-hot grant = decode(gnt_idx) when gnt_en=1, else 8'd0.
- busy     output  1  1 in GRANT state.
- timeout  output  1  one-cycle pulse on a forced revoke.

Behaviour:
- One clock; reset is synchronous and active-high. On rst=1 at a clk edge, all of the following take effect at that edge, regardless of state:
  - state=IDLE, ptr=3'd0, gnt_idx=3'd0, gnt_en=0, gnt=8'd0, busy=0, timeout=0, hold_cnt=0.
- States: IDLE, GRANT.
- IDLE, arbitration:
  - If req != 0, the winner is the first set bit scanning ptr, ptr+1, ..., ptr+7, modulo 8.
  - At the next edge: gnt_idx=winner, gnt_en=1, hold_cnt=0, state=GRANT.
  - Latency from a req sampled in IDLE to a visible grant is 1 clock.
  - If req == 0, remain in IDLE; outputs unchanged.
- GRANT:
  - Only req[gnt_idx] is observed; other requests wait.
  - hold_cnt increments every cycle the grant is not ended.
- Grant end conditions, evaluated each edge in GRANT:
  - (a) release=1 or req[gnt_idx]=0, a normal release. timeout stays 0.
  - (b) hold_cnt == MAX_HOLD-1 with (a) false, a forced revoke. timeout=1 for exactly one cycle.
  - On either end: gnt_en=0, state=IDLE, ptr=(gnt_idx+1) mod 8 with natural 3-bit wrap (7 -> 0).
- Simultaneous release and hold limit: the normal release wins; no timeout pulse.
- Break-before-make:
  - After any grant end, gnt_en stays 0 for at least one full cycle before the next grant.
  - The minimum owner-to-owner gap is therefore 1 idle cycle.
  - The same agent may win again only after the other requesters' turns (ptr has advanced past it).
- Owner grant length:
  - Grant is visible for MAX_HOLD cycles maximum.
  - With MAX_HOLD=1, every grant lasts exactly 1 cycle; timeout pulses unless a release is present.
- gnt:
  - Combinational decode of registered gnt_idx/gnt_en, so always consistent with them.
  - Never has more than one bit set.
- busy equals gnt_en.
- Requests that drop in IDLE before arbitration are simply not granted; no request memory.
- Width rules: ptr and gnt_idx wrap modulo 8; hold_cnt never exceeds MAX_HOLD-1.

Decomposition:
- Shared package:
  - State encoding constants: IDLE=1'b0, GRANT=1'b1.
  - NUM_REQ=8, IDX_W=3.
  - Default MAX_HOLD.
- One sub-module: rr_grant_decoder, a combinational 3-to-8 decoder with enable (in[2:0], en, out[7:0]; out=0 when en=0). Instantiated once to form gnt.
- Priority scan, counter and FSM live in rr_decode_arbiter.

Test Plan:
- Reset release with req=8'b0000_0000 -> gnt_en=0, gnt=8'h00, gnt_idx=0, timeout=0 for 5 cycles.
- req=8'b1000_0001 held, release pulsed after 3 grant cycles each time -> grant order 0, 7, 0, 7; gnt=8'h01 then 8'h80; one gnt_en=0 cycle between each owner.
- req=8'b0000_0100 held, release=0, MAX_HOLD=16 -> gnt=8'h04 for 16 cycles; timeout=1 on the cycle gnt_en falls; agent 2 re-granted after a 1-cycle gap.
- Release on the same edge as the hold limit (release=1 when hold_cnt=15) -> grant drops, timeout stays 0.
- Owner 5 granted, req[5] drops to 0 -> grant ends next edge, ptr=6; with req=8'b0110_0001 the next winner is 6, then 0.
- rst=1 asserted while gnt=8'h10 -> at that edge gnt=8'h00, ptr=0; after rst falls with req=8'b1111_1111, the first grant goes to agent 0.
